// File: rtl/pll_lock_manager.sv
// pll_lock_manager: sequences PLL reset, qualifies LOCK, retries on timeout,
// and gates the system reset; everything runs on the PLL reference clock.
// Ports: REFERENCECLK clock, RESETB async reset (low), LOCK raw PLL lock,
//   FORCE_RELOCK restart pulse; PLL_RESETB/PLL_BYPASS PLL controls,
//   SYS_RESETB downstream reset (low), LOCKED/FAULT status,
//   RELOCK_COUNT saturating count of lock losses while running.
module pll_lock_manager #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 4,
  parameter bit BYPASS_ON_FAULT     = 1'b0
) (
  input  logic       REFERENCECLK,
  input  logic       RESETB,
  input  logic       LOCK,
  input  logic       FORCE_RELOCK,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       SYS_RESETB,
  output logic       LOCKED,
  output logic       FAULT,
  output logic [7:0] RELOCK_COUNT
);

  localparam int AB = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                      PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CMAX = (AB > LOCK_STABLE_CYCLES) ?
                        AB : LOCK_STABLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] retry, retry_n;
  logic [7:0]    relock_n;
  logic          lock_m, lock_s;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    retry_n  = retry;
    relock_n = RELOCK_COUNT;
    if (FORCE_RELOCK) begin
      state_n = S_PLL_RST;
      cnt_n   = '0;
      retry_n = '0;
      // a loss seen on the same cycle as the request is still one loss
      if (state == S_RUN && !lock_s && RELOCK_COUNT != 8'hFF)
        relock_n = RELOCK_COUNT + 8'd1;
    end else begin
      unique case (state)
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // the sample that ends the wait is the first stable sample
          if (lock_s) begin
            if (STB_LAST == '0) begin
              state_n = S_RUN;
              cnt_n   = '0;
              retry_n = '0;
            end else begin
              state_n = S_STABLE;
              cnt_n   = CW'(1);
            end
          end else if (cnt == TMO_LAST) begin
            retry_n = retry + RW'(1);
            cnt_n   = '0;
            state_n = (retry_n == RTY_MAX) ? S_FAULT : S_PLL_RST;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STB_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
            retry_n = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
            if (RELOCK_COUNT != 8'hFF)
              relock_n = RELOCK_COUNT + 8'd1;
          end
        end
        S_FAULT: begin
        end
        default: begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they change with it
  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      lock_m       <= 1'b0;
      lock_s       <= 1'b0;
      state        <= S_PLL_RST;
      cnt          <= '0;
      retry        <= '0;
      RELOCK_COUNT <= 8'd0;
      PLL_RESETB   <= 1'b0;
      PLL_BYPASS   <= 1'b0;
      SYS_RESETB   <= 1'b0;
      LOCKED       <= 1'b0;
      FAULT        <= 1'b0;
    end else begin
      lock_m       <= LOCK;
      lock_s       <= lock_m;
      state        <= state_n;
      cnt          <= cnt_n;
      retry        <= retry_n;
      RELOCK_COUNT <= relock_n;
      PLL_RESETB   <= state_n inside {S_WAIT_LOCK, S_STABLE, S_RUN};
      PLL_BYPASS   <= (state_n == S_FAULT) && BYPASS_ON_FAULT;
      SYS_RESETB   <= (state_n == S_RUN) ||
                      ((state_n == S_FAULT) && BYPASS_ON_FAULT);
      LOCKED       <= (state_n == S_RUN);
      FAULT        <= (state_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_manager.sv
// tb_pll_lock_manager: randomized and directed bench for pll_lock_manager,
// two instances (bypass off/on) checked against a behavioural model.
module tb_pll_lock_manager;

  localparam int RC = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 3;

  localparam int M_RST = 0;
  localparam int M_ACQ = 1;
  localparam int M_RUN = 2;
  localparam int M_FLT = 3;

  logic clk, rstb, lock, force_r;
  logic prb_a, byp_a, sys_a, lkd_a, flt_a;
  logic prb_b, byp_b, sys_b, lkd_b, flt_b;
  logic [7:0] rc_a, rc_b;
  logic [12:0] dut_a, dut_b;

  int n_chk, n_pass;

  int m_mode, m_age, m_ones, m_zeros, m_retry, m_relock;
  bit m_p0, m_p1;

  assign dut_a = {prb_a, byp_a, sys_a, lkd_a, flt_a, rc_a};
  assign dut_b = {prb_b, byp_b, sys_b, lkd_b, flt_b, rc_b};

  pll_lock_manager #(
    .PLL_RESET_CYCLES(RC), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(SC), .MAX_RETRIES(MR), .BYPASS_ON_FAULT(1'b0)
  ) u_dut_a (
    .REFERENCECLK(clk), .RESETB(rstb), .LOCK(lock),
    .FORCE_RELOCK(force_r), .PLL_RESETB(prb_a), .PLL_BYPASS(byp_a),
    .SYS_RESETB(sys_a), .LOCKED(lkd_a), .FAULT(flt_a),
    .RELOCK_COUNT(rc_a)
  );

  pll_lock_manager #(
    .PLL_RESET_CYCLES(RC), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(SC), .MAX_RETRIES(MR), .BYPASS_ON_FAULT(1'b1)
  ) u_dut_b (
    .REFERENCECLK(clk), .RESETB(rstb), .LOCK(lock),
    .FORCE_RELOCK(force_r), .PLL_RESETB(prb_b), .PLL_BYPASS(byp_b),
    .SYS_RESETB(sys_b), .LOCKED(lkd_b), .FAULT(flt_b),
    .RELOCK_COUNT(rc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = M_RST; m_age = 0; m_ones = 0; m_zeros = 0;
    m_retry = 0; m_relock = 0; m_p0 = 1'b0; m_p1 = 1'b0;
  endfunction

  function automatic void model_enter_rst();
    m_mode = M_RST;
    m_age = 0;
  endfunction

  // one reference clock edge; s is the lock value two samples old
  function automatic void model_step();
    bit s;
    s = m_p1;
    m_p1 = m_p0;
    m_p0 = lock;
    if (force_r) begin
      if (m_mode == M_RUN && !s && m_relock < 255) m_relock++;
      m_retry = 0;
      model_enter_rst();
    end else begin
      case (m_mode)
        M_RST: begin
          m_age++;
          if (m_age == RC) begin
            m_mode = M_ACQ; m_ones = 0; m_zeros = 0;
          end
        end
        M_ACQ: begin
          if (s) begin
            m_ones++; m_zeros = 0;
            if (m_ones == SC) begin m_mode = M_RUN; m_retry = 0; end
          end else if (m_ones > 0) begin
            m_ones = 0; m_zeros = 0;
          end else begin
            m_zeros++;
            if (m_zeros == TO) begin
              m_retry++;
              if (m_retry == MR) m_mode = M_FLT;
              else model_enter_rst();
            end
          end
        end
        M_RUN: begin
          if (!s) begin
            if (m_relock < 255) m_relock++;
            model_enter_rst();
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [12:0] exp_out(input bit byp);
    bit run, flt;
    run = (m_mode == M_RUN);
    flt = (m_mode == M_FLT);
    return {(m_mode == M_ACQ) || run, flt && byp, run || (flt && byp),
            run, flt, 8'(m_relock)};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rstb) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0; lock = 1'b0; force_r = 1'b0;
    model_reset();
    repeat (3) tick();
    n_chk++;
    if (dut_a !== 13'h0 || dut_b !== 13'h0)
      $display("FAIL reset_values: a=%h b=%h want 0000/0000", dut_a, dut_b);
    else n_pass++;
  endtask

  task automatic test_acquire();
    int low, rise;
    rstb = 1'b1; lock = 1'b0; low = 0;
    while (!prb_a && low < 50) begin
      tick(); low++;
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL acquire_model: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    n_chk++;
    if (low !== RC)
      $display("FAIL pll_reset_width: got %0d want %0d", low, RC);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL acquire_wait: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    lock = 1'b1; rise = 0;
    while (!sys_a && rise < 50) begin
      tick(); rise++;
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL acquire_stable: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    n_chk++;
    if (rise !== 2 + SC || lkd_a !== 1'b1)
      $display("FAIL lock_to_run: got %0d cycles locked=%b want %0d/1",
               rise, lkd_a, 2 + SC);
    else n_pass++;
  endtask

  task automatic test_force_relock();
    int rc0;
    rc0 = rc_a;
    lock = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL force_pre: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    force_r = 1'b1;
    tick();
    force_r = 1'b0;
    n_chk++;
    if (rc_a !== 8'(rc0 + 1) || prb_a !== 1'b0 || lkd_a !== 1'b0 ||
        sys_a !== 1'b0)
      $display("FAIL force_coincident: rc=%0d prb=%b lkd=%b sys=%b want %0d/0/0/0",
               rc_a, prb_a, lkd_a, sys_a, rc0 + 1);
    else n_pass++;
    lock = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL force_recover: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    force_r = 1'b1;
    tick();
    force_r = 1'b0;
    n_chk++;
    if (rc_a !== 8'(rc0 + 1) || lkd_a !== 1'b0 || prb_a !== 1'b0)
      $display("FAIL force_in_run: rc=%0d lkd=%b prb=%b want %0d/0/0",
               rc_a, lkd_a, prb_a, rc0 + 1);
    else n_pass++;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL force_rerun: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    int r, rise;
    rstb = 1'b0; model_reset(); lock = 1'b1;
    tick();
    rstb = 1'b1; r = 0;
    while (!prb_a && r < 50) begin
      tick(); r++;
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL glitch_rst: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    rise = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL glitch_model: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
      if (sys_a && rise < 0) rise = k;
      if (k == 3) lock = 1'b0;
      if (k == 4) lock = 1'b1;
    end
    n_chk++;
    if (rise !== 14)
      $display("FAIL glitch_restart: release at %0d want 14", rise);
    else n_pass++;
  endtask

  task automatic test_fault();
    int pulses, first;
    logic prev;
    rstb = 1'b0; lock = 1'b0; model_reset();
    tick();
    rstb = 1'b1;
    pulses = 0; first = -1; prev = prb_a;
    for (int k = 1; k <= 80; k++) begin
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL fault_model: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
      if (prb_a && !prev) pulses++;
      prev = prb_a;
      if (flt_a && first < 0) first = k;
    end
    n_chk++;
    if (pulses !== MR || first !== MR * (RC + TO))
      $display("FAIL fault_timing: pulses=%0d at=%0d want %0d/%0d",
               pulses, first, MR, MR * (RC + TO));
    else n_pass++;
    n_chk++;
    if ({flt_a, sys_a, byp_a, prb_a} !== 4'b1000)
      $display("FAIL fault_outputs: f/s/b/p=%b want 1000",
               {flt_a, sys_a, byp_a, prb_a});
    else n_pass++;
    n_chk++;
    if ({flt_b, sys_b, byp_b, prb_b} !== 4'b1110)
      $display("FAIL fault_bypass: f/s/b/p=%b want 1110",
               {flt_b, sys_b, byp_b, prb_b});
    else n_pass++;
    force_r = 1'b1;
    tick();
    force_r = 1'b0;
    n_chk++;
    if ({flt_a, flt_b, byp_b, sys_b, prb_a, prb_b} !== 6'b0 ||
        rc_a !== 8'd0)
      $display("FAIL force_in_fault: flags=%b rc=%0d want 000000/0",
               {flt_a, flt_b, byp_b, sys_b, prb_a, prb_b}, rc_a);
    else n_pass++;
  endtask

  task automatic test_relock_sat();
    int n, lat;
    lock = 1'b1; n = 0;
    while (!lkd_a && n < 100) begin
      tick(); n++;
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL sat_lock: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    for (int i = 0; i < 300; i++) begin
      lock = 1'b0; lat = 0;
      while (sys_a && lat < 10) begin
        tick(); lat++;
        n_chk++;
        if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
          $display("FAIL sat_drop: a=%h b=%h want %h/%h",
                   dut_a, dut_b, exp_out(0), exp_out(1));
        else n_pass++;
      end
      n_chk++;
      if (lat !== 3)
        $display("FAIL drop_latency: drop %0d got %0d want 3", i, lat);
      else n_pass++;
      lock = 1'b1; n = 0;
      while (!lkd_a && n < 100) begin
        tick(); n++;
        n_chk++;
        if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
          $display("FAIL sat_relock: a=%h b=%h want %h/%h",
                   dut_a, dut_b, exp_out(0), exp_out(1));
        else n_pass++;
      end
      n_chk++;
      if (lkd_a !== 1'b1)
        $display("FAIL relock_timeout: drop %0d locked=%b want 1", i, lkd_a);
      else n_pass++;
    end
    n_chk++;
    if (rc_a !== 8'd255 || rc_b !== 8'd255)
      $display("FAIL relock_saturate: rc=%0d/%0d want 255", rc_a, rc_b);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int n;
    rstb = 1'b0; model_reset();
    tick();
    rstb = 1'b1; lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!lkd_a && n < 100) begin
        tick(); n++;
        n_chk++;
        if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
          $display("FAIL async_lock: a=%h b=%h want %h/%h",
                   dut_a, dut_b, exp_out(0), exp_out(1));
        else n_pass++;
      end
      if (i < 7) begin
        lock = 1'b0; n = 0;
        while (lkd_a && n < 10) begin
          tick(); n++;
          n_chk++;
          if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
            $display("FAIL async_drop: a=%h b=%h want %h/%h",
                     dut_a, dut_b, exp_out(0), exp_out(1));
          else n_pass++;
        end
        if (i < 6) lock = 1'b1;
        else break;
      end
    end
    n = 0;
    while (!prb_a && n < 20) begin
      tick(); n++;
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL async_wait: a=%h b=%h want %h/%h",
                 dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) tick();
    n_chk++;
    if (rc_a !== 8'd7 || prb_a !== 1'b1 || lkd_a !== 1'b0)
      $display("FAIL async_setup: rc=%0d prb=%b lkd=%b want 7/1/0",
               rc_a, prb_a, lkd_a);
    else n_pass++;
    #3;
    rstb = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (dut_a !== 13'h0 || dut_b !== 13'h0)
      $display("FAIL async_reset: a=%h b=%h want 0000/0000", dut_a, dut_b);
    else n_pass++;
    tick();
    rstb = 1'b1;
  endtask

  task automatic test_random();
    int seg, hold;
    seg = 0; hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) rstb = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        rstb = 1'b0;
        model_reset();
        hold = $urandom_range(1, 3);
      end
      if (seg == 0) begin
        seg = $urandom_range(1, 40);
        lock = ($urandom_range(0, 3) != 0);
      end
      seg--;
      force_r = ($urandom_range(0, 149) == 0);
      tick();
      n_chk++;
      if (dut_a !== exp_out(0) || dut_b !== exp_out(1))
        $display("FAIL random_model: cyc %0d a=%h b=%h want %h/%h",
                 k, dut_a, dut_b, exp_out(0), exp_out(1));
      else n_pass++;
    end
    force_r = 1'b0;
    rstb = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rstb = 1'b0; lock = 1'b0; force_r = 1'b0;
    model_reset();
    test_reset();
    test_acquire();
    test_force_relock();
    test_glitch();
    test_fault();
    test_relock_sat();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
